// File: rtl/watch_rtc_if.sv
// Keypad, mode and display signals of the watch; master drives keypad/mode, slave is the watch.
interface watch_rtc_if;
    logic       dip_sw;
    logic [9:0] keypad;
    logic       fmt_12h;
    logic [7:0] seg_data;
    logic [7:0] seg_com;
    logic       pm;
    logic       key_err;
    logic       time_valid;

    modport master (
        output dip_sw, keypad, fmt_12h,
        input  seg_data, seg_com, pm, key_err, time_valid
    );

    modport slave (
        input  dip_sw, keypad, fmt_12h,
        output seg_data, seg_com, pm, key_err, time_valid
    );
endinterface

// File: rtl/watch_rtc.sv
// HH:MM:SS watch with validated six-digit keypad entry, atomic commit and a multiplexed
// 7-segment display carrying a blinking entry cursor and an optional 12-hour format.
module watch_rtc #(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned SCAN_DIV      = 1,
    parameter int unsigned BLINK_TICKS   = 250
) (
    input logic        clk,
    input logic        rst,
    watch_rtc_if.slave bus
);
    localparam int unsigned TickW  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    // Digit order: 0=h_ten 1=h_one 2=m_ten 3=m_one 4=s_ten 5=s_one.
    logic [5:0][3:0]   time_q, shadow_q;
    logic [2:0]        cursor_q, scan_idx_q;
    logic [TickW-1:0]  tick_q;
    logic [ScanW-1:0]  scan_cnt_q;
    logic [BlinkW-1:0] blink_cnt_q;
    logic              blink_q, dip_prev_q, time_valid_q, key_err_q, pm_q;
    logic [9:0]        keypad_prev_q;
    logic [7:0]        seg_data_q, seg_com_q;

    logic            key_evt, set_evt, key_ok, dip_rise, commit;
    logic [3:0]      key_val, key_lim, src_digit;
    logic            src_blank;
    logic [5:0][3:0] shadow_wr, time_inc, disp_time;
    logic [4:0]      hour, hour12;

    function automatic logic [7:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hFC;
            4'd1:    return 8'h60;
            4'd2:    return 8'hDA;
            4'd3:    return 8'hF2;
            4'd4:    return 8'h66;
            4'd5:    return 8'hB6;
            4'd6:    return 8'hBE;
            4'd7:    return 8'hE4;
            4'd8:    return 8'hFE;
            4'd9:    return 8'hF6;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] com_dec(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h7F;
            3'd1:    return 8'hBF;
            3'd2:    return 8'hDF;
            3'd3:    return 8'hEF;
            3'd4:    return 8'hF7;
            3'd5:    return 8'hFB;
            default: return 8'hFF;
        endcase
    endfunction

    always_comb begin
        key_val = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (bus.keypad[k]) key_val = 4'(k);
        end
    end

    assign key_evt  = (bus.keypad != '0) && ((bus.keypad & (bus.keypad - 10'd1)) == '0) &&
                      (keypad_prev_q == '0);
    assign dip_rise = bus.dip_sw && !dip_prev_q;
    // Requiring dip_prev_q drops keys that coincide with either dip_sw edge.
    assign set_evt  = key_evt && bus.dip_sw && dip_prev_q;
    assign key_ok   = key_val <= key_lim;
    assign commit   = set_evt && key_ok && (cursor_q == 3'd5);

    always_comb begin
        case (cursor_q)
            3'd0:       key_lim = 4'd2;
            3'd1:       key_lim = (shadow_q[0] == 4'd2) ? 4'd3 : 4'd9;
            3'd2, 3'd4: key_lim = 4'd5;
            default:    key_lim = 4'd9;
        endcase
    end

    always_comb begin
        shadow_wr = shadow_q;
        shadow_wr[cursor_q] = key_val;
        // An h_ten of 2 would otherwise leave an hour above 23 in the shadow.
        if (cursor_q == 3'd0 && key_val == 4'd2 && shadow_q[1] > 4'd3) shadow_wr[1] = 4'd0;
    end

    always_comb begin
        time_inc = time_q;
        if (time_q[5] != 4'd9) begin
            time_inc[5] = time_q[5] + 4'd1;
        end else begin
            time_inc[5] = 4'd0;
            if (time_q[4] != 4'd5) begin
                time_inc[4] = time_q[4] + 4'd1;
            end else begin
                time_inc[4] = 4'd0;
                if (time_q[3] != 4'd9) begin
                    time_inc[3] = time_q[3] + 4'd1;
                end else begin
                    time_inc[3] = 4'd0;
                    if (time_q[2] != 4'd5) begin
                        time_inc[2] = time_q[2] + 4'd1;
                    end else begin
                        time_inc[2] = 4'd0;
                        if (time_q[0] == 4'd2 && time_q[1] == 4'd3) begin
                            time_inc[0] = 4'd0;
                            time_inc[1] = 4'd0;
                        end else if (time_q[1] == 4'd9) begin
                            time_inc[1] = 4'd0;
                            time_inc[0] = time_q[0] + 4'd1;
                        end else begin
                            time_inc[1] = time_q[1] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign hour = 5'(time_q[0]) * 5'd10 + 5'(time_q[1]);

    always_comb begin
        if (hour == 5'd0)       hour12 = 5'd12;
        else if (hour > 5'd12)  hour12 = hour - 5'd12;
        else                    hour12 = hour;
        disp_time = time_q;
        if (bus.fmt_12h) begin
            disp_time[0] = (hour12 >= 5'd10) ? 4'd1 : 4'd0;
            disp_time[1] = 4'((hour12 >= 5'd10) ? hour12 - 5'd10 : hour12);
        end
        if (bus.dip_sw) begin
            src_digit = shadow_q[scan_idx_q];
            src_blank = (scan_idx_q == cursor_q) && !blink_q;
        end else begin
            src_digit = disp_time[scan_idx_q];
            src_blank = bus.fmt_12h && (scan_idx_q == 3'd0) && (disp_time[0] == 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            time_q        <= '0;
            shadow_q      <= '0;
            cursor_q      <= '0;
            scan_idx_q    <= '0;
            tick_q        <= '0;
            scan_cnt_q    <= '0;
            blink_cnt_q   <= '0;
            blink_q       <= 1'b1;
            dip_prev_q    <= 1'b0;
            time_valid_q  <= 1'b0;
            key_err_q     <= 1'b0;
            pm_q          <= 1'b0;
            keypad_prev_q <= '0;
            seg_data_q    <= 8'h00;
            seg_com_q     <= 8'hFF;
        end else begin
            keypad_prev_q <= bus.keypad;
            dip_prev_q    <= bus.dip_sw;
            key_err_q     <= set_evt && !key_ok;
            pm_q          <= hour >= 5'd12;
            seg_com_q     <= com_dec(scan_idx_q);
            seg_data_q    <= src_blank ? 8'h00 : seg_enc(src_digit);

            if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
                scan_cnt_q <= '0;
                scan_idx_q <= (scan_idx_q == 3'd5) ? 3'd0 : scan_idx_q + 3'd1;
            end else begin
                scan_cnt_q <= scan_cnt_q + ScanW'(1);
            end

            if (dip_rise) begin
                shadow_q <= time_q;
                cursor_q <= 3'd0;
            end else if (set_evt && key_ok) begin
                shadow_q <= shadow_wr;
                cursor_q <= (cursor_q == 3'd5) ? 3'd0 : cursor_q + 3'd1;
            end

            if (!bus.dip_sw || dip_rise || (set_evt && key_ok)) begin
                blink_q     <= 1'b1;
                blink_cnt_q <= '0;
            end else if (blink_cnt_q == BlinkW'(BLINK_TICKS - 1)) begin
                blink_q     <= !blink_q;
                blink_cnt_q <= '0;
            end else begin
                blink_cnt_q <= blink_cnt_q + BlinkW'(1);
            end

            if (commit) begin
                time_q       <= shadow_wr;
                time_valid_q <= 1'b1;
                tick_q       <= '0;
            end else if (time_valid_q) begin
                if (tick_q == TickW'(TICKS_PER_SEC - 1)) begin
                    tick_q <= '0;
                    time_q <= time_inc;
                end else begin
                    tick_q <= tick_q + TickW'(1);
                end
            end
        end
    end

    assign bus.seg_data   = seg_data_q;
    assign bus.seg_com    = seg_com_q;
    assign bus.pm         = pm_q;
    assign bus.key_err    = key_err_q;
    assign bus.time_valid = time_valid_q;
endmodule
